// File: rtl/pred_bram_readback_streamer_if.sv
// Bus bundle for the prediction readback streamer: the read-only BRAM port
// (address/enable out, data back) and the AXI-Stream master toward the DMA.
interface pred_bram_readback_streamer_if #(
  parameter int PRED_BITS      = 2,
  parameter int BRAM_ADDR_BITS = 14,
  parameter int DATA_WIDTH     = 32
) ();
  logic [BRAM_ADDR_BITS-1:0] rd_ADDR;
  logic                      rd_EN;
  logic [PRED_BITS-1:0]      rd_DATA;
  logic [DATA_WIDTH-1:0]     m_TDATA;
  logic                      m_TVALID;
  logic                      m_TREADY;
  logic                      m_TLAST;

  // streamer side
  modport master (
    output rd_ADDR, rd_EN, m_TDATA, m_TVALID, m_TLAST,
    input  rd_DATA, m_TREADY
  );

  // BRAM + stream sink side
  modport slave (
    input  rd_ADDR, rd_EN, m_TDATA, m_TVALID, m_TLAST,
    output rd_DATA, m_TREADY
  );
endinterface

// File: rtl/pred_bram_readback_streamer.sv
// Streams 2-bit predictions out of the prediction BRAM, packed LSB-first into
// AXI-Stream words. Two word buffers: a pack register filled slot by slot and
// an output register holding the beat on the bus. A completed word bypasses
// the pack register straight into the output register when that is free, so
// with TREADY high one word leaves every 16 cycles.
module pred_bram_readback_streamer #(
  parameter int PRED_BITS      = 2,
  parameter int BRAM_ADDR_BITS = 14,
  parameter int DATA_WIDTH     = 32
) (
  input  logic                      ap_clk,
  input  logic                      ap_rst_n,
  input  logic                      start,
  input  logic [BRAM_ADDR_BITS-1:0] base_addr,
  input  logic [BRAM_ADDR_BITS:0]   num_preds,
  output logic                      busy,
  output logic                      done,
  pred_bram_readback_streamer_if.master bus
);

  localparam int PREDS_PER_WORD = DATA_WIDTH / PRED_BITS;
  localparam int SLOT_W         = $clog2(PREDS_PER_WORD);
  localparam int CNT_W          = SLOT_W + 1;
  localparam int REM_W          = BRAM_ADDR_BITS + 1;

  typedef enum logic [1:0] {IDLE, READ, DRAIN, FIN} state_t;

  state_t                    state_q, state_d;
  logic [BRAM_ADDR_BITS-1:0] addr_q, addr_d;         // next address to read (drives rd_ADDR)
  logic [REM_W-1:0]          rem_q, rem_d;           // predictions still to be read
  logic [CNT_W-1:0]          cnt_q, cnt_d;           // pack slots filled or in flight
  logic [SLOT_W-1:0]         slot_q, slot_d;         // slot the arriving read lands in
  logic                      rvalid_q, rvalid_d;     // rd_DATA carries a read this cycle
  logic                      rlast_q, rlast_d;       // ...and it is the run's final prediction
  logic [DATA_WIDTH-1:0]     pack_q, pack_d;
  logic                      pack_full_q, pack_full_d; // complete word parked, waiting for output
  logic                      pack_last_q, pack_last_d;
  logic [DATA_WIDTH-1:0]     out_data_q, out_data_d;
  logic                      out_vld_q, out_vld_d;
  logic                      out_last_q, out_last_d;

  logic                      start_ok, out_fire, out_free, word_done, move, rd_en;
  logic [CNT_W-1:0]          cnt_eff;
  logic [DATA_WIDTH-1:0]     pack_w;

  // Handshake, word completion and read-issue decisions for this cycle.
  // Reads resume in the very cycle a full pack moves out, hence cnt_eff.
  always_comb begin
    start_ok  = (state_q == IDLE) && start;
    out_fire  = out_vld_q && bus.m_TREADY;
    out_free  = !out_vld_q || out_fire;
    pack_w    = pack_q;
    pack_w[int'(slot_q)*PRED_BITS +: PRED_BITS] = bus.rd_DATA;
    word_done = rvalid_q && ((slot_q == SLOT_W'(PREDS_PER_WORD-1)) || rlast_q);
    move      = out_free && (pack_full_q || word_done);
    cnt_eff   = move ? '0 : cnt_q;
    rd_en     = (state_q == READ) && (cnt_eff < CNT_W'(PREDS_PER_WORD));
  end

  // Run control: next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (num_preds == '0) ? FIN : READ;
      READ:    if (rd_en && (rem_q == REM_W'(1))) state_d = DRAIN;
      DRAIN:   if (out_fire && out_last_q) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Address/count bookkeeping, slot packing and output register loading.
  always_comb begin
    addr_d      = addr_q;
    rem_d       = rem_q;
    cnt_d       = cnt_eff + CNT_W'(rd_en);
    slot_d      = slot_q;
    rvalid_d    = rd_en;
    rlast_d     = rd_en && (rem_q == REM_W'(1));
    pack_d      = pack_q;
    pack_full_d = pack_full_q;
    pack_last_d = pack_last_q;
    out_data_d  = out_data_q;
    out_vld_d   = out_vld_q;
    out_last_d  = out_last_q;

    if (start_ok) begin
      addr_d      = base_addr;
      rem_d       = num_preds;
      cnt_d       = '0;
      slot_d      = '0;
      pack_d      = '0;
      pack_full_d = 1'b0;
    end else if (rd_en) begin
      addr_d = addr_q + 1'b1;   // wraps modulo BRAM depth
      rem_d  = rem_q - 1'b1;
    end

    if (rvalid_q) begin
      slot_d = slot_q + 1'b1;
      if (!word_done) pack_d = pack_w;
    end

    if (move) begin
      // a parked word never coexists with an arriving read
      out_data_d  = pack_full_q ? pack_q : pack_w;
      out_last_d  = pack_full_q ? pack_last_q : rlast_q;
      out_vld_d   = 1'b1;
      pack_d      = '0;
      pack_full_d = 1'b0;
    end else begin
      if (word_done) begin
        pack_d      = pack_w;
        pack_full_d = 1'b1;
        pack_last_d = rlast_q;
      end
      if (out_fire) out_vld_d = 1'b0;
    end
  end

  // State registers; async reset drops everything including in-flight reads.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      rvalid_q    <= 1'b0;
      rlast_q     <= 1'b0;
      pack_q      <= '0;
      pack_full_q <= 1'b0;
      pack_last_q <= 1'b0;
      out_data_q  <= '0;
      out_vld_q   <= 1'b0;
      out_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      rvalid_q    <= rvalid_d;
      rlast_q     <= rlast_d;
      pack_q      <= pack_d;
      pack_full_q <= pack_full_d;
      pack_last_q <= pack_last_d;
      out_data_q  <= out_data_d;
      out_vld_q   <= out_vld_d;
      out_last_q  <= out_last_d;
    end
  end

  assign busy         = (state_q != IDLE);
  assign done         = (state_q == FIN);
  assign bus.rd_ADDR  = addr_q;
  assign bus.rd_EN    = rd_en;
  assign bus.m_TDATA  = out_data_q;
  assign bus.m_TVALID = out_vld_q;
  assign bus.m_TLAST  = out_last_q;

endmodule

// File: tb/tb_pred_bram_readback_streamer.sv
// Bench for the prediction readback streamer: BRAM model with 1-cycle read
// latency, random TREADY, expected-beat queue filled at start and drained by
// the stream monitor, plus a vector table and hand sequences for corner cases.
module tb_pred_bram_readback_streamer;

  localparam int DEPTH = 16384;

  logic        ap_clk, ap_rst_n, start, busy, done;
  logic [13:0] base_addr;
  logic [14:0] num_preds;

  pred_bram_readback_streamer_if #(.PRED_BITS(2), .BRAM_ADDR_BITS(14), .DATA_WIDTH(32)) bus ();

  pred_bram_readback_streamer dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start(start),
    .base_addr(base_addr), .num_preds(num_preds),
    .busy(busy), .done(done), .bus(bus)
  );

  typedef struct packed {logic [31:0] data; logic last;} beat_t;
  typedef struct {
    int base; int num; int mode; int pct;
    int exp_beats; logic [31:0] exp_first; logic [31:0] exp_last; bit chk_lat;
  } vec_t;

  logic [1:0] mem [0:DEPTH-1];
  beat_t      exp_q[$];
  int         addr_log[$];
  int n_checks = 0, n_fail = 0;
  int cyc = 0, tready_pct = 100;
  int beats, reads, acc, max_out, stall_bad, tvalid_seen, first_vld_cyc, last_hs_cyc;
  int done_cnt = 0, done_cyc = 0, t0;
  logic [31:0] first_word, last_word, prev_data;
  logic prev_last, prev_stall = 1'b0;

  initial begin ap_clk = 0; forever #5 ap_clk = ~ap_clk; end
  initial forever begin @(posedge ap_clk); cyc++; end

  // BRAM read port, 1-cycle latency
  initial begin
    bus.rd_DATA = '0;
    forever begin
      @(posedge ap_clk);
      if (bus.rd_EN) bus.rd_DATA <= mem[bus.rd_ADDR];
    end
  end

  initial begin
    bus.m_TREADY = 1'b0;
    forever begin
      @(posedge ap_clk);
      #1 bus.m_TREADY = ($urandom_range(99) < tready_pct);
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // stream/read monitor, sampled mid-cycle
  initial forever begin
    @(negedge ap_clk);
    if (done) begin done_cnt++; done_cyc = cyc; end
    if (bus.rd_EN) begin addr_log.push_back(int'(bus.rd_ADDR)); reads++; end
    if (bus.m_TVALID) begin
      tvalid_seen++;
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
    end
    if (prev_stall && (!bus.m_TVALID || bus.m_TDATA !== prev_data || bus.m_TLAST !== prev_last))
      stall_bad++;
    prev_stall = bus.m_TVALID && !bus.m_TREADY;
    prev_data  = bus.m_TDATA;
    prev_last  = bus.m_TLAST;
    if (bus.m_TVALID && bus.m_TREADY) begin
      acc++; beats++; last_hs_cyc = cyc;
      if (beats == 1) first_word = bus.m_TDATA;
      last_word = bus.m_TDATA;
      if (exp_q.size() == 0) chk("extra_beat", 64'(beats), 64'(0));
      else begin
        beat_t e;
        e = exp_q.pop_front();
        chk("beat_data", 64'(bus.m_TDATA), 64'(e.data));
        chk("beat_last", 64'(bus.m_TLAST), 64'(e.last));
      end
    end
    if (reads - 16*acc > max_out) max_out = reads - 16*acc;
  end

  task automatic clr_mon();
    beats = 0; reads = 0; acc = 0; max_out = 0; stall_bad = 0; tvalid_seen = 0;
    first_vld_cyc = -1; last_hs_cyc = -1; addr_log.delete();
  endtask

  task automatic fill_mem(input int mode);
    for (int i = 0; i < DEPTH; i++)
      case (mode)
        0: mem[i] = 2'(i % 4);
        1: mem[i] = 2'b11;
        default: mem[i] = (i >= 16380) ? 2'd1 : (i < 4) ? 2'd2 : 2'd0;
      endcase
  endtask

  task automatic push_expected(input int base, input int num);
    int nb;
    logic [31:0] w;
    nb = (num + 15) / 16;
    for (int b = 0; b < nb; b++) begin
      w = '0;
      for (int j = 0; j < 16; j++)
        if (b*16 + j < num) w[2*j +: 2] = mem[(base + b*16 + j) % DEPTH];
      exp_q.push_back('{data: w, last: (b == nb-1)});
    end
  endtask

  task automatic do_start(input int base, input int num);
    @(posedge ap_clk); #1;
    start = 1'b1; base_addr = 14'(base); num_preds = 15'(num); t0 = cyc;
    @(posedge ap_clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int d0, i;
    d0 = done_cnt;
    i = 0;
    while (done_cnt == d0 && i < bound) begin @(negedge ap_clk); i++; end
    if (done_cnt == d0) chk({name, "_timeout"}, 64'(0), 64'(1));
  endtask

  task automatic run_vec(input vec_t v, input string name);
    int d0, bad;
    fill_mem(v.mode);
    clr_mon();
    exp_q.delete();
    push_expected(v.base, v.num);
    tready_pct = v.pct;
    d0 = done_cnt;
    do_start(v.base, v.num);
    wait_done(v.num*5 + 200, name);
    repeat (3) @(negedge ap_clk);
    chk({name, "_beats"}, 64'(beats), 64'(v.exp_beats));
    chk({name, "_first"}, 64'(first_word), 64'(v.exp_first));
    chk({name, "_lastw"}, 64'(last_word), 64'(v.exp_last));
    chk({name, "_left"}, 64'(exp_q.size()), 64'(0));
    chk({name, "_ndone"}, 64'(done_cnt - d0), 64'(1));
    chk({name, "_done_at"}, 64'(done_cyc), 64'(last_hs_cyc + 1));
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_stable"}, 64'(stall_bad), 64'(0));
    chk({name, "_cap"}, 64'(max_out <= 32), 64'(1));
    chk({name, "_nreads"}, 64'(addr_log.size()), 64'(v.num));
    bad = 0;
    for (int k = 0; k < v.num && k < addr_log.size(); k++)
      if (addr_log[k] != (v.base + k) % DEPTH) bad++;
    chk({name, "_addr"}, 64'(bad), 64'(0));
    if (v.chk_lat) chk({name, "_lat"}, 64'(first_vld_cyc - t0), 64'(18));
    tready_pct = 100;
  endtask

  task automatic chk_outputs_zero(input string name);
    chk({name, "_busy"}, 64'(busy), 64'(0));
    chk({name, "_done"}, 64'(done), 64'(0));
    chk({name, "_rden"}, 64'(bus.rd_EN), 64'(0));
    chk({name, "_rdaddr"}, 64'(bus.rd_ADDR), 64'(0));
    chk({name, "_tvalid"}, 64'(bus.m_TVALID), 64'(0));
    chk({name, "_tdata"}, 64'(bus.m_TDATA), 64'(0));
    chk({name, "_tlast"}, 64'(bus.m_TLAST), 64'(0));
  endtask

  vec_t vecs[6];

  initial begin
    int d0, i;
    vecs[0] = '{0,     32,    0, 100, 2,    32'hE4E4E4E4, 32'hE4E4E4E4, 1'b1};
    vecs[1] = '{100,   17,    1, 100, 2,    32'hFFFFFFFF, 32'h00000003, 1'b1};
    vecs[2] = '{16380, 8,     2, 100, 1,    32'h0000AA55, 32'h0000AA55, 1'b0};
    vecs[3] = '{0,     32,    0, 30,  2,    32'hE4E4E4E4, 32'hE4E4E4E4, 1'b0};
    vecs[4] = '{7,     1,     0, 100, 1,    32'h00000003, 32'h00000003, 1'b0};
    vecs[5] = '{5,     16384, 0, 100, 1024, 32'h39393939, 32'h39393939, 1'b1};

    start = 1'b0; base_addr = '0; num_preds = '0;
    ap_rst_n = 1'b0;
    #12 chk_outputs_zero("reset");
    @(negedge ap_clk); ap_rst_n = 1'b1;
    repeat (2) @(negedge ap_clk);

    for (int v = 0; v < 6; v++) run_vec(vecs[v], $sformatf("vec%0d", v));

    // num=0, plus a start held into the done cycle which must be ignored
    clr_mon(); exp_q.delete();
    @(posedge ap_clk); #1;
    start = 1'b1; base_addr = 14'd0; num_preds = 15'd0;
    @(posedge ap_clk); #1;
    num_preds = 15'd16;
    @(negedge ap_clk);
    chk("zero_busy", 64'(busy), 64'(1));
    chk("zero_done", 64'(done), 64'(1));
    @(posedge ap_clk); #1;
    start = 1'b0;
    @(negedge ap_clk);
    chk("zero_idle", 64'(busy), 64'(0));
    chk("zero_done2", 64'(done), 64'(0));
    repeat (30) @(negedge ap_clk);
    chk("zero_tvalid", 64'(tvalid_seen), 64'(0));
    chk("zero_reads", 64'(reads), 64'(0));

    // second start while busy is ignored
    fill_mem(0); clr_mon(); exp_q.delete();
    push_expected(0, 32);
    d0 = done_cnt;
    do_start(0, 32);
    repeat (5) @(negedge ap_clk);
    do_start(9, 16);
    wait_done(400, "busy_start");
    repeat (30) @(negedge ap_clk);
    chk("busy_start_beats", 64'(beats), 64'(2));
    chk("busy_start_left", 64'(exp_q.size()), 64'(0));
    chk("busy_start_ndone", 64'(done_cnt - d0), 64'(1));

    // reset in the middle of a beat
    clr_mon(); exp_q.delete();
    push_expected(0, 64);
    do_start(0, 64);
    i = 0;
    while (!bus.m_TVALID && i < 100) begin @(negedge ap_clk); i++; end
    chk("rst_mid_saw_valid", 64'(bus.m_TVALID), 64'(1));
    d0 = done_cnt;
    #2 ap_rst_n = 1'b0;
    #1 chk_outputs_zero("rst_mid");
    repeat (2) @(negedge ap_clk);
    exp_q.delete();
    ap_rst_n = 1'b1;
    repeat (5) @(negedge ap_clk);
    chk("rst_mid_nodone", 64'(done_cnt - d0), 64'(0));
    chk("rst_mid_tvalid", 64'(bus.m_TVALID), 64'(0));
    run_vec('{40, 16, 0, 100, 1, 32'hE4E4E4E4, 32'hE4E4E4E4, 1'b1}, "after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got cycle %0d required finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
